// File: rtl/ctrl_pkg.sv
// ctrl_pkg: instruction-class, opcode and ALU command constants plus the execute control bundle.
package ctrl_pkg;
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       s;
    logic       b;
  } ctrl_bundle_t;
  // Unlisted data-processing opcodes map to EXE_NOP, which also marks them as NOPs.
  function automatic logic [3:0] dp_cmd(input logic [3:0] op);
    case (op)
      OP_AND, OP_TST: return EXE_AND;
      OP_EOR:         return EXE_EOR;
      OP_SUB, OP_CMP: return EXE_SUB;
      OP_ADD:         return EXE_ADD;
      OP_ADC:         return EXE_ADC;
      OP_SBC:         return EXE_SBC;
      OP_ORR:         return EXE_ORR;
      OP_MOV:         return EXE_MOV;
      OP_MVN:         return EXE_MVN;
      default:        return EXE_NOP;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_decode_stage_if.sv
// ctrl_decode_stage_if: upstream instruction, flush and downstream control-bundle signals of the ID stage.
interface ctrl_decode_stage_if #(parameter int REG_AW = 4);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [3:0]        op_code;
  logic              s_in;
  logic              imm;
  logic [REG_AW-1:0] rn;
  logic [REG_AW-1:0] rm;
  logic [REG_AW-1:0] rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        exe_cmd;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en;
  logic              s;
  logic              b;
  logic [REG_AW-1:0] out_rd;
  logic              hazard;
  modport master (
    output in_valid, mode, op_code, s_in, imm, rn, rm, rd, flush, out_ready,
    input  in_ready, out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, out_rd, hazard
  );
  modport slave (
    input  in_valid, mode, op_code, s_in, imm, rn, rm, rd, flush, out_ready,
    output in_ready, out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, out_rd, hazard
  );
endinterface

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: pure decode of mode/op_code/s_in/imm into the control bundle and source-use flags.
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [1:0]   mode,
  input  logic [3:0]   op_code,
  input  logic         s_in,
  input  logic         imm,
  output ctrl_bundle_t ctrl,
  output logic         rn_used,
  output logic         rm_used,
  output logic         rd_used
);
  logic       is_dp;
  logic       is_mem;
  logic       is_br;
  logic [3:0] dp;
  logic       dp_ok;
  always_comb begin
    is_dp         = mode == MODE_DP;
    is_mem        = mode == MODE_MEM;
    is_br         = mode == MODE_BR;
    dp            = dp_cmd(op_code);
    dp_ok         = is_dp && dp != EXE_NOP;
    ctrl.exe_cmd  = dp_ok ? dp : is_mem ? EXE_ADD : EXE_NOP;
    ctrl.mem_r_en = is_mem && s_in;
    ctrl.mem_w_en = is_mem && !s_in;
    ctrl.wb_en    = (dp_ok && op_code != OP_TST && op_code != OP_CMP) || (is_mem && s_in);
    ctrl.s        = (dp_ok || is_br) && s_in;
    ctrl.b        = is_br;
    rn_used       = (is_dp && op_code != OP_MOV && op_code != OP_MVN) || is_mem;
    rm_used       = is_dp && !imm;
    rd_used       = is_mem && !s_in;
  end
endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: ID-stage decode, ID/EX bundle register, RAW scoreboard and branch flush.
// Define CTRL_FWD_EN to stall only on load-use hazards (ALU results forwarded).
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int TRACK_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  ctrl_decode_stage_if.slave bus
);
`ifdef CTRL_FWD_EN
  localparam bit LOAD_ONLY = 1'b1;
`else
  localparam bit LOAD_ONLY = 1'b0;
`endif
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } sb_t;
  ctrl_bundle_t      dec;
  ctrl_bundle_t      q;
  logic              q_v;
  logic [REG_AW-1:0] q_rd;
  logic              rn_used;
  logic              rm_used;
  logic              rd_used;
  sb_t               sb  [TRACK_DEPTH];
  sb_t               trk [TRACK_DEPTH+1];
  logic              hz;
  logic              accept;
  logic              xfer;
  ctrl_decode_comb u_dec (
    .mode    (bus.mode),
    .op_code (bus.op_code),
    .s_in    (bus.s_in),
    .imm     (bus.imm),
    .ctrl    (dec),
    .rn_used (rn_used),
    .rm_used (rm_used),
    .rd_used (rd_used)
  );
  // trk[0] is the output register acting as the youngest writer; trk[1..] are the shifted entries.
  always_comb begin
    trk[0] = {q_v && q.wb_en, q_rd, q.mem_r_en};
    for (int i = 0; i < TRACK_DEPTH; i++) trk[i+1] = sb[i];
    hz = 1'b0;
    for (int i = 0; i <= TRACK_DEPTH; i++)
      hz = hz | (trk[i].v && (trk[i].ld || !LOAD_ONLY) &&
                 ((rn_used && bus.rn == trk[i].rd) ||
                  (rm_used && bus.rm == trk[i].rd) ||
                  (rd_used && bus.rd == trk[i].rd)));
  end
  assign bus.hazard   = bus.in_valid && hz;
  assign bus.in_ready = !bus.hazard && !bus.flush && (!q_v || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = q_v && bus.out_ready && !bus.flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_v  <= 1'b0;
      q    <= '0;
      q_rd <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) sb[i] <= '0;
    end else begin
      q_v   <= bus.flush ? 1'b0 : accept ? 1'b1 : bus.out_ready ? 1'b0 : q_v;
      q     <= bus.flush ? '0 : accept ? dec : q;
      q_rd  <= accept ? bus.rd : q_rd;
      sb[0] <= xfer ? trk[0] : '0;
      for (int i = 1; i < TRACK_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end
  assign bus.out_valid = q_v;
  assign bus.exe_cmd   = q.exe_cmd;
  assign bus.mem_r_en  = q.mem_r_en;
  assign bus.mem_w_en  = q.mem_w_en;
  assign bus.wb_en     = q.wb_en;
  assign bus.s         = q.s;
  assign bus.b         = q.b;
  assign bus.out_rd    = q_rd;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ctrl_decode_stage;
  localparam int AW = 4;
  localparam int TD = 2;
`ifdef CTRL_FWD_EN
  localparam bit LOAD_ONLY = 1'b1;
`else
  localparam bit LOAD_ONLY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  ctrl_decode_stage_if #(.REG_AW(AW)) bus ();
  ctrl_decode_stage #(.REG_AW(AW), .TRACK_DEPTH(TD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int dp_tab [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
  function automatic logic [8:0] ref_dec(input int md, input int op, input int si);
    logic [3:0] e = 4'd0;
    logic mr = 0, mw = 0, wb = 0, s = 0, b = 0;
    if (md == 0 && dp_tab[op] >= 0) begin
      e  = 4'(dp_tab[op]);
      wb = !(op == 8 || op == 10);
      s  = si[0];
    end else if (md == 1) begin
      e = 4'd2; wb = si[0]; mr = si[0]; mw = !si[0];
    end else if (md == 2) begin
      b = 1; s = si[0];
    end
    return {e, mr, mw, wb, s, b};
  endfunction
  function automatic logic [8:0] dut_bun();
    return {bus.exe_cmd, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.s, bus.b};
  endfunction
  task automatic drive(input bit iv, input int md, input int op, input bit si, input bit im,
                       input int a, input int m, input int d, input bit fl, input bit ordy);
    bus.in_valid = iv; bus.mode = 2'(md); bus.op_code = 4'(op); bus.s_in = si; bus.imm = im;
    bus.rn = AW'(a); bus.rm = AW'(m); bus.rd = AW'(d); bus.flush = fl; bus.out_ready = ordy;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    drive(0, 3, 0, 0, 1, 0, 0, 0, 0, 1);
    repeat (n) tick();
  endtask
  task automatic test_reset();
    drive(1, 0, 4, 1, 0, 1, 1, 1, 0, 1);
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_tests++;
    if (dut_bun() !== 9'h0) begin n_fail++; $display("FAIL reset_bundle got %h want 000", dut_bun()); end
    n_tests++;
    if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", bus.hazard); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_add();
    drive(1, 0, 4, 1, 0, 0, 1, 2, 0, 1);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", bus.out_valid); end
    n_tests++;
    if (dut_bun() !== {4'b0010, 5'b00110}) begin n_fail++; $display("FAIL add_bundle got %h want %h", dut_bun(), {4'b0010, 5'b00110}); end
    n_tests++;
    if (bus.out_rd !== 4'd2) begin n_fail++; $display("FAIL add_rd got %0d want 2", bus.out_rd); end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", bus.out_valid); end
    idle(3);
  endtask
  task automatic test_raw_stall();
    int  stall = 0;
    bit  done = 0;
    drive(1, 1, 0, 1, 0, 0, 0, 3, 0, 1);
    tick();
    drive(1, 0, 4, 0, 0, 3, 4, 5, 0, 1);
    for (int k = 0; k < 10 && !done; k++) begin
      #1;
      if (bus.in_ready) done = 1;
      else begin
        if (bus.hazard) stall++;
        tick();
      end
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL raw_timeout got in_ready 0 want 1 within 10 cycles"); end
    n_tests++;
    if (stall != TD + 1) begin n_fail++; $display("FAIL raw_stall_len got %0d want %0d", stall, TD + 1); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (!bus.out_valid || bus.exe_cmd !== 4'b0010 || bus.out_rd !== 4'd5) begin
      n_fail++; $display("FAIL raw_accept got v=%b cmd=%h rd=%0d want v=1 cmd=2 rd=5", bus.out_valid, bus.exe_cmd, bus.out_rd);
    end
    idle(4);
    drive(1, 1, 0, 1, 0, 0, 0, 3, 0, 1);
    tick();
    drive(1, 0, 4, 0, 0, 3, 4, 5, 0, 1);
    #1;
    n_tests++;
    if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got %b want 1", bus.hazard); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.hazard !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear got v=%b hz=%b want 0 0", bus.out_valid, bus.hazard);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_back_to_back();
    drive(1, 0, 4, 0, 0, 1, 4, 2, 0, 1);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %b want 1", bus.in_ready); end
    tick();
    drive(1, 0, 2, 0, 0, 5, 6, 7, 0, 1);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.hazard !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got rdy=%b hz=%b want 1 0", bus.in_ready, bus.hazard);
    end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (!bus.out_valid || bus.exe_cmd !== 4'b0100 || bus.out_rd !== 4'd7) begin
      n_fail++; $display("FAIL b2b_out got v=%b cmd=%h rd=%0d want v=1 cmd=4 rd=7", bus.out_valid, bus.exe_cmd, bus.out_rd);
    end
    idle(4);
  endtask
  task automatic test_backpressure();
    drive(1, 0, 12, 0, 1, 9, 10, 8, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 12, 0, 11, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b0 || !bus.out_valid || bus.exe_cmd !== 4'b0111 || bus.out_rd !== 4'd8) begin
        n_fail++; $display("FAIL bp_hold%0d got rdy=%b v=%b cmd=%h rd=%0d want 0 1 7 8", k, bus.in_ready, bus.out_valid, bus.exe_cmd, bus.out_rd);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (!bus.out_valid || bus.exe_cmd !== 4'b1000 || bus.out_rd !== 4'd11) begin
      n_fail++; $display("FAIL bp_next got v=%b cmd=%h rd=%0d want 1 8 11", bus.out_valid, bus.exe_cmd, bus.out_rd);
    end
    idle(4);
  endtask
  task automatic test_flush();
    drive(1, 2, 0, 1, 1, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (!bus.out_valid || dut_bun() !== 9'b0000_00011) begin
      n_fail++; $display("FAIL flush_branch got v=%b bun=%h want 1 003", bus.out_valid, dut_bun());
    end
    drive(1, 0, 4, 0, 0, 1, 2, 3, 1, 1);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", bus.in_ready); end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || dut_bun() !== 9'h0) begin
      n_fail++; $display("FAIL flush_clear got v=%b bun=%h want 0 000", bus.out_valid, dut_bun());
    end
    drive(0, 0, 4, 0, 0, 1, 2, 3, 0, 1);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_noaccept got %b want 0", bus.out_valid); end
    idle(3);
  endtask
  task automatic test_nop();
    drive(1, 3, 4, 1, 0, 0, 0, 4, 0, 1);
    tick();
    n_tests++;
    if (!bus.out_valid || dut_bun() !== 9'h0) begin
      n_fail++; $display("FAIL nop_mode3 got v=%b bun=%h want 1 000", bus.out_valid, dut_bun());
    end
    drive(1, 0, 3, 1, 1, 0, 0, 4, 0, 1);
    tick();
    n_tests++;
    if (!bus.out_valid || dut_bun() !== 9'h0) begin
      n_fail++; $display("FAIL nop_op3 got v=%b bun=%h want 1 000", bus.out_valid, dut_bun());
    end
    drive(1, 0, 4, 0, 0, 4, 4, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (bus.hazard !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL nop_nosb%0d got hz=%b rdy=%b want 0 1", k, bus.hazard, bus.in_ready);
      end
      tick();
      bus.rd = 4'd9;
    end
    idle(4);
  endtask
  function automatic bit uses(input int w, input int a, input int m, input int d,
                              input bit un, input bit um, input bit ud);
    return (un && a == w) || (um && m == w) || (ud && d == w);
  endfunction
  task automatic test_random();
    bit m_ov = 0;
    logic [8:0] m_bun = '0;
    int m_rd = 0;
    int w_rd[$], w_ld[$], w_age[$];
    int n_rd[$], n_ld[$], n_age[$];
    bit iv, si, im, fl, ordy, un, um, ud, eh, er, acc, xf;
    int md, op, a, m, d;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      iv = $urandom_range(0, 9) < 8; md = $urandom_range(0, 3); op = $urandom_range(0, 15);
      si = 1'($urandom_range(0, 1)); im = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 3); m = $urandom_range(0, 3); d = $urandom_range(0, 3);
      fl = $urandom_range(0, 9) == 0; ordy = $urandom_range(0, 9) < 7;
      drive(iv, md, op, si, im, a, m, d, fl, ordy);
      #1;
      un = (md == 0 && op != 13 && op != 15) || md == 1;
      um = md == 0 && !im;
      ud = md == 1 && !si;
      eh = m_ov && m_bun[2] && (!LOAD_ONLY || m_bun[4]) && uses(m_rd, a, m, d, un, um, ud);
      foreach (w_rd[k]) if (!LOAD_ONLY || w_ld[k] != 0) eh |= uses(w_rd[k], a, m, d, un, um, ud);
      eh = eh && iv;
      er = !eh && !fl && (!m_ov || ordy);
      n_tests++;
      if (bus.hazard !== eh) begin n_fail++; $display("FAIL rnd_hazard c=%0d got %b want %b", c, bus.hazard, eh); end
      n_tests++;
      if (bus.in_ready !== er) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, bus.in_ready, er); end
      acc = iv && er;
      xf = m_ov && ordy && !fl;
      n_rd.delete(); n_ld.delete(); n_age.delete();
      foreach (w_rd[k]) if (w_age[k] + 1 <= TD) begin
        n_rd.push_back(w_rd[k]); n_ld.push_back(w_ld[k]); n_age.push_back(w_age[k] + 1);
      end
      if (xf && m_bun[2]) begin n_rd.push_back(m_rd); n_ld.push_back(int'(m_bun[4])); n_age.push_back(1); end
      w_rd = n_rd; w_ld = n_ld; w_age = n_age;
      if (fl) begin m_ov = 0; m_bun = '0; end
      else if (acc) begin m_ov = 1; m_bun = ref_dec(md, op, int'(si)); m_rd = d; end
      else if (ordy) m_ov = 0;
      tick();
      n_tests++;
      if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.out_valid, m_ov); end
      n_tests++;
      if (dut_bun() !== m_bun) begin n_fail++; $display("FAIL rnd_bundle c=%0d got %h want %h", c, dut_bun(), m_bun); end
      if (m_ov) begin
        n_tests++;
        if (int'(bus.out_rd) != m_rd) begin n_fail++; $display("FAIL rnd_rd c=%0d got %0d want %0d", c, bus.out_rd, m_rd); end
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(0, 3, 0, 0, 1, 0, 0, 0, 0, 1);
    test_reset();
    test_add();
    test_raw_stall();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_nop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
